fifo_sync_flags: RTL and testbench

Parametrised synchronous FIFO, the successor to the basic sync FIFO macro in the standard macros library. Adds non-power-of-two depth, show-ahead (first-word-fall-through) read data, simultaneous read/write at full, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Used as the general buffering primitive between peripheral datapaths and bus-side logic in a single clock domain.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_wrap_ptr.sv | 35 +++
 rtl/fifo_sync_flags.sv | 114 +++++++++++
 tb/tb_fifo_sync_flags.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous flag FIFO: pointer wrap arithmetic that
// works for any depth, not just powers of two.
package fifo_pkg;

    function automatic int unsigned fifo_next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// AW-bit FIFO pointer that advances on en and wraps from DEPTH-1 back to 0.
// A synchronous clear takes priority over an advance.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          clear,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear)
            ptr_d = '0;
        else if (en)
            ptr_d = AW'(fifo_next_ptr(32'(ptr_q), DEPTH));
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock show-ahead FIFO with any depth, threshold flags and sticky
// overflow/underflow. A write at full is accepted when a read frees the slot.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [AW:0]           data_count,
    output logic                  empty,
    output logic                  full,
    input  logic [AW:0]           af_th,
    input  logic [AW:0]           ae_th,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic                  rd_go, wr_go;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    // clear masks both requests so nothing moves in the flush cycle
    assign rd_go  = rd_acc & ~clear;
    assign wr_go  = wr_acc & ~clear;

    fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rd_ptr (
        .clk     (clk),
        .reset_b (reset_b),
        .clear   (clear),
        .en      (rd_go),
        .ptr     (rd_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_wr_ptr (
        .clk     (clk),
        .reset_b (reset_b),
        .clear   (clear),
        .en      (wr_go),
        .ptr     (wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_go)
            mem_q[wr_ptr] <= data_in;
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // a new error event outranks err_clr in the same cycle
            if (wr_en & ~wr_acc)
                overflow_d = 1'b1;
            else if (err_clr)
                overflow_d = 1'b0;
            if (rd_en & empty)
                underflow_d = 1'b1;
            else if (err_clr)
                underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out     = mem_q[rd_ptr];
    assign data_count   = count_q;
    assign almost_full  = (count_q >= af_th);
    assign almost_empty = (count_q <= ae_th);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: an 8-deep FIFO for boundary/error behaviour and a 5-deep
// FIFO for non-power-of-two wrap and threshold flags.
module tb_fifo_sync_flags;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 8-deep instance
    logic        a_clear = 0, a_wr = 0, a_rd = 0, a_eclr = 0;
    logic [31:0] a_din = 0, a_dout;
    logic [3:0]  a_cnt, a_af = 4'd6, a_ae = 4'd1;
    logic        a_empty, a_full, a_afl, a_ael, a_ovf, a_unf;

    fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) u_a (
        .clk(clk), .reset_b(reset_b), .clear(a_clear), .wr_en(a_wr),
        .data_in(a_din), .rd_en(a_rd), .data_out(a_dout), .data_count(a_cnt),
        .empty(a_empty), .full(a_full), .af_th(a_af), .ae_th(a_ae),
        .almost_full(a_afl), .almost_empty(a_ael), .overflow(a_ovf),
        .underflow(a_unf), .err_clr(a_eclr)
    );

    // 5-deep instance
    logic        b_clear = 0, b_wr = 0, b_rd = 0, b_eclr = 0;
    logic [7:0]  b_din = 0, b_dout;
    logic [3:0]  b_cnt, b_af = 4'd4, b_ae = 4'd1;
    logic        b_empty, b_full, b_afl, b_ael, b_ovf, b_unf;

    fifo_sync_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_b (
        .clk(clk), .reset_b(reset_b), .clear(b_clear), .wr_en(b_wr),
        .data_in(b_din), .rd_en(b_rd), .data_out(b_dout), .data_count(b_cnt),
        .empty(b_empty), .full(b_full), .af_th(b_af), .ae_th(b_ae),
        .almost_full(b_afl), .almost_empty(b_ael), .overflow(b_ovf),
        .underflow(b_unf), .err_clr(b_eclr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a();
        for (int i = 0; i < 8; i++) begin
            a_wr  = 1;
            a_din = 32'((i + 1) * 'h11);
            step();
            chk("a_fill_cnt", 64'(a_cnt), 64'(i + 1));
        end
        a_wr = 0;
        chk("a_fill_full", 64'(a_full), 64'd1);
    endtask

    initial begin
        #3;
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        chk("rst_empty", 64'(a_empty), 64'd1);
        chk("rst_full", 64'(a_full), 64'd0);
        chk("rst_ae", 64'(a_ael), 64'd1);
        chk("rst_af", 64'(a_afl), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_unf", 64'(a_unf), 64'd0);
        @(negedge clk);
        reset_b = 1;

        // fill to full, then one rejected write
        fill_a();
        chk("a_af_full", 64'(a_afl), 64'd1);
        chk("a_ae_full", 64'(a_ael), 64'd0);
        a_wr = 1; a_din = 32'h99;
        step();
        a_wr = 0;
        chk("a_ovf_set", 64'(a_ovf), 64'd1);
        chk("a_ovf_cnt", 64'(a_cnt), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("a_rd_order", 64'(a_dout), 64'((i + 1) * 'h11));
            a_rd = 1;
            step();
        end
        a_rd = 0;
        chk("a_drain_empty", 64'(a_empty), 64'd1);
        chk("a_drain_cnt", 64'(a_cnt), 64'd0);
        a_eclr = 1;
        step();
        a_eclr = 0;
        chk("a_eclr", 64'(a_ovf), 64'd0);

        // simultaneous read/write at full
        fill_a();
        a_wr = 1; a_rd = 1; a_din = 32'hAA;
        step();
        a_wr = 0;
        chk("a_fullrw_dout", 64'(a_dout), 64'h22);
        chk("a_fullrw_cnt", 64'(a_cnt), 64'd8);
        chk("a_fullrw_ovf", 64'(a_ovf), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("a_fullrw_order", 64'(a_dout), (i < 7) ? 64'((i + 2) * 'h11) : 64'hAA);
            step();
        end
        a_rd = 0;
        chk("a_fullrw_empty", 64'(a_empty), 64'd1);

        // simultaneous read/write at empty
        a_wr = 1; a_rd = 1; a_din = 32'h55;
        step();
        a_wr = 0;
        chk("a_emprw_unf", 64'(a_unf), 64'd1);
        chk("a_emprw_cnt", 64'(a_cnt), 64'd1);
        chk("a_emprw_dout", 64'(a_dout), 64'h55);
        step();
        a_rd = 0;
        chk("a_emprw_empty", 64'(a_empty), 64'd1);

        // clear with count 3 and overflow set, write requested alongside
        fill_a();
        a_wr = 1; a_din = 32'h99;
        step();
        a_wr = 0; a_rd = 1;
        for (int i = 0; i < 5; i++) step();
        a_rd = 0;
        chk("a_pre_clr_cnt", 64'(a_cnt), 64'd3);
        chk("a_pre_clr_ovf", 64'(a_ovf), 64'd1);
        a_clear = 1; a_wr = 1; a_din = 32'h77;
        step();
        a_clear = 0; a_wr = 0;
        chk("a_clr_cnt", 64'(a_cnt), 64'd0);
        chk("a_clr_empty", 64'(a_empty), 64'd1);
        chk("a_clr_ovf", 64'(a_ovf), 64'd0);
        chk("a_clr_unf", 64'(a_unf), 64'd0);

        // err_clr loses to a concurrent overflow event
        fill_a();
        a_wr = 1; a_eclr = 1; a_din = 32'h99;
        step();
        a_wr = 0; a_eclr = 0;
        chk("a_eclr_vs_ovf", 64'(a_ovf), 64'd1);

        // asynchronous reset between edges
        #2 reset_b = 0;
        #1;
        chk("a_async_cnt", 64'(a_cnt), 64'd0);
        chk("a_async_empty", 64'(a_empty), 64'd1);
        chk("a_async_ovf", 64'(a_ovf), 64'd0);
        @(negedge clk);
        reset_b = 1;

        // depth 5: streaming pairs across several pointer wraps
        b_wr = 1; b_din = 8'hB0;
        step();
        for (int k = 1; k < 12; k++) begin
            chk("b_stream_dout", 64'(b_dout), 64'(8'hB0 + k - 1));
            b_rd = 1; b_din = 8'(8'hB0 + k);
            step();
            chk("b_stream_cnt", 64'(b_cnt), 64'd1);
        end
        b_wr = 0;
        chk("b_stream_last", 64'(b_dout), 64'hBB);
        step();
        b_rd = 0;
        chk("b_stream_empty", 64'(b_empty), 64'd1);

        // depth 5: threshold flags
        for (int i = 0; i < 5; i++) begin
            b_wr = 1; b_din = 8'(8'hC0 + i);
            step();
            chk("b_af", 64'(b_afl), (i + 1 >= 4) ? 64'd1 : 64'd0);
            chk("b_ae", 64'(b_ael), (i + 1 <= 1) ? 64'd1 : 64'd0);
        end
        b_wr = 0;
        chk("b_full", 64'(b_full), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("b_rd_order", 64'(b_dout), 64'(8'hC0 + i));
            b_rd = 1;
            step();
            chk("b_af_drain", 64'(b_afl), (4 - i >= 4) ? 64'd1 : 64'd0);
        end
        b_rd = 0;
        chk("b_end_empty", 64'(b_empty), 64'd1);
        chk("b_end_unf", 64'(b_unf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
